// File: rtl/apb_slave_bank.sv
// Zero-wait-state APB2 completer backed by a reset-cleared 32-bit register bank.
// Define APB_SLV_PROTCHK_EN to build the protocol-violation checker (prot_err/err_cnt).
module apb_slave_bank #(
  parameter int SEL_IDX = 0,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16
) (
  input  logic             Hclk,
  input  logic             Hrest,
  input  logic [3:0]       Pselx,
  input  logic             Penable,
  input  logic             Pwrite,
  input  logic [31:0]      Paddr,
  input  logic [31:0]      Pwdata,
  output logic [31:0]      Prdata,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] rd_cnt,
  output logic             prot_err,
  output logic [7:0]       err_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_idx;
  logic            r_wr;
  logic [31:0]     r_bank [DEPTH];

  logic            w_sel;
  logic [AW-1:0]   w_idx;
  logic            w_setup;
  logic            w_complete;
  logic            w_wr_commit;
  logic            w_rd_commit;

  assign w_sel       = Pselx[SEL_IDX];
  assign w_idx       = Paddr[AW+1:2];
  assign w_setup     = w_sel & ~Penable;
  // A transfer only completes when its access phase directly follows a sampled setup.
  assign w_complete  = w_sel & Penable & (r_state == ST_SETUP);
  assign w_wr_commit = w_complete & r_wr;
  assign w_rd_commit = w_complete & ~r_wr;

  // Address bits above the bank and the other selects are intentionally ignored.
  logic w_unused;
  assign w_unused = ^{Paddr[31:AW+2], Paddr[1:0], Pselx};

  always_ff @(posedge Hclk or posedge Hrest) begin
    if (Hrest) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_wr    <= 1'b0;
      Prdata  <= '0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else begin
      if (!w_sel)        r_state <= ST_IDLE;
      else if (!Penable) r_state <= ST_SETUP;
      else               r_state <= ST_ACCESS;

      if (w_setup) begin
        r_idx <= w_idx;
        r_wr  <= Pwrite;
        if (!Pwrite) Prdata <= r_bank[w_idx];
      end

      if (w_wr_commit && wr_cnt != '1) wr_cnt <= wr_cnt + CNT_W'(1);
      if (w_rd_commit && rd_cnt != '1) rd_cnt <= rd_cnt + CNT_W'(1);
    end
  end

  // NOTE: the bank is architecturally reset-cleared, so every word is a flop with async reset rather than an inferred RAM.
  always_ff @(posedge Hclk or posedge Hrest) begin
    if (Hrest) begin
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
    end else if (w_wr_commit) begin
      r_bank[r_idx] <= Pwdata;
    end
  end

`ifdef APB_SLV_PROTCHK_EN
  logic w_viol;

  // Access without a preceding setup, or an access phase that moved the address/direction.
  assign w_viol = w_sel & Penable &
                  ((r_state != ST_SETUP) | (w_idx != r_idx) | (Pwrite != r_wr));

  always_ff @(posedge Hclk or posedge Hrest) begin
    if (Hrest) begin
      prot_err <= 1'b0;
      err_cnt  <= '0;
    end else if (w_viol) begin
      prot_err <= 1'b1;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign prot_err = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_apb_slave_bank.sv
// Directed bench for apb_slave_bank: a default instance plus a CNT_W=3 twin for saturation.
module tb_apb_slave_bank;

  logic        Hclk = 1'b0;
  logic        Hrest;
  logic [3:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata, Prdata_s;
  logic [15:0] wr_cnt, rd_cnt;
  logic [2:0]  wr_cnt_s, rd_cnt_s;
  logic        prot_err, prot_err_s;
  logic [7:0]  err_cnt, err_cnt_s;
  logic [31:0] d;

  int checks = 0;
  int errors = 0;

`ifdef APB_SLV_PROTCHK_EN
  localparam bit PC = 1'b1;
`else
  localparam bit PC = 1'b0;
`endif

  always #5 Hclk = ~Hclk;

  apb_slave_bank dut (
    .Hclk(Hclk), .Hrest(Hrest), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt),
    .prot_err(prot_err), .err_cnt(err_cnt)
  );

  apb_slave_bank #(.SEL_IDX(0), .DEPTH(16), .CNT_W(3)) dut_sat (
    .Hclk(Hclk), .Hrest(Hrest), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata_s), .wr_cnt(wr_cnt_s), .rd_cnt(rd_cnt_s),
    .prot_err(prot_err_s), .err_cnt(err_cnt_s)
  );

  task automatic tick;
    @(posedge Hclk);
    #1;
  endtask

  task automatic do_reset;
    Hrest = 1'b1; Pselx = '0; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
    tick; tick;
    Hrest = 1'b0;
  endtask

  task automatic idle;
    Pselx = '0; Penable = 1'b0;
    tick;
  endtask

  task automatic apb_write(input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] data);
    Pselx = sel; Pwrite = 1'b1; Paddr = addr; Pwdata = data; Penable = 1'b0;
    tick;
    Penable = 1'b1;
    tick;
  endtask

  // Returns Prdata as seen during the access cycle.
  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    Pselx = 4'b0001; Pwrite = 1'b0; Paddr = addr; Penable = 1'b0;
    tick;
    data = Prdata;
    Penable = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (Prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata got %h exp %h", Prdata, 32'h0); end
    checks++; if (wr_cnt !== 16'h0) begin errors++; $display("FAIL reset_wr_cnt got %h exp %h", wr_cnt, 16'h0); end
    checks++; if (rd_cnt !== 16'h0) begin errors++; $display("FAIL reset_rd_cnt got %h exp %h", rd_cnt, 16'h0); end
    checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL reset_prot_err got %b exp 0", prot_err); end
    checks++; if (err_cnt !== 8'h0) begin errors++; $display("FAIL reset_err_cnt got %h exp 00", err_cnt); end
  endtask

  task automatic test_read_all;
    for (int i = 0; i < 16; i++) begin
      apb_read(32'(i * 4), d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL read_all_word%0d got %h exp %h", i, d, 32'h0); end
    end
    idle;
    checks++; if (rd_cnt !== 16'd16) begin errors++; $display("FAIL read_all_rd_cnt got %0d exp 16", rd_cnt); end
    checks++; if (wr_cnt !== 16'd0) begin errors++; $display("FAIL read_all_wr_cnt got %0d exp 0", wr_cnt); end
    checks++; if (rd_cnt_s !== 3'd7) begin errors++; $display("FAIL read_all_rd_sat got %0d exp 7", rd_cnt_s); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    apb_write(4'b0001, 32'h08, 32'hDEADBEEF);
    apb_read(32'h08, d);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_data got %h exp %h", d, 32'hDEADBEEF); end
    idle;
    checks++; if (Prdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_prdata_hold got %h exp %h", Prdata, 32'hDEADBEEF); end
    checks++; if (wr_cnt !== 16'd1) begin errors++; $display("FAIL b2b_wr_cnt got %0d exp 1", wr_cnt); end
    checks++; if (rd_cnt !== 16'd1) begin errors++; $display("FAIL b2b_rd_cnt got %0d exp 1", rd_cnt); end
  endtask

  task automatic test_wrap_and_select;
    do_reset;
    apb_write(4'b0010, 32'h40, 32'h12345678);
    idle;
    apb_read(32'h00, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL other_sel_word0 got %h exp %h", d, 32'h0); end
    checks++; if (wr_cnt !== 16'd0) begin errors++; $display("FAIL other_sel_wr_cnt got %0d exp 0", wr_cnt); end
    apb_write(4'b1111, 32'h40, 32'h12345678);
    apb_read(32'h00, d);
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL wrap_word0 got %h exp %h", d, 32'h12345678); end
    checks++; if (wr_cnt !== 16'd1) begin errors++; $display("FAIL wrap_wr_cnt got %0d exp 1", wr_cnt); end
    idle;
  endtask

  task automatic test_saturation;
    do_reset;
    for (int i = 0; i < 10; i++) apb_write(4'b0001, 32'(i * 4), 32'(i + 32'h100));
    apb_read(32'h24, d);
    checks++; if (d !== 32'h109) begin errors++; $display("FAIL sat_word9 got %h exp %h", d, 32'h109); end
    idle;
    checks++; if (wr_cnt !== 16'd10) begin errors++; $display("FAIL sat_wr_cnt got %0d exp 10", wr_cnt); end
    checks++; if (wr_cnt_s !== 3'd7) begin errors++; $display("FAIL sat_wr_cnt_small got %0d exp 7", wr_cnt_s); end
  endtask

  task automatic test_protocol;
    do_reset;
    Pselx = 4'b0001; Pwrite = 1'b1; Paddr = 32'h04; Pwdata = 32'hFFFFFFFF; Penable = 1'b1;
    tick;
    idle;
    checks++; if (prot_err !== PC) begin errors++; $display("FAIL noset_prot_err got %b exp %b", prot_err, PC); end
    checks++; if (err_cnt !== (PC ? 8'd1 : 8'd0)) begin errors++; $display("FAIL noset_err_cnt got %0d exp %0d", err_cnt, PC ? 1 : 0); end
    checks++; if (wr_cnt !== 16'd0) begin errors++; $display("FAIL noset_wr_cnt got %0d exp 0", wr_cnt); end
    Pselx = 4'b0001; Pwrite = 1'b1; Paddr = 32'h04; Pwdata = 32'hA5A5A5A5; Penable = 1'b0;
    tick;
    Paddr = 32'h0C; Penable = 1'b1;
    tick;
    idle;
    checks++; if (err_cnt !== (PC ? 8'd2 : 8'd0)) begin errors++; $display("FAIL moved_err_cnt got %0d exp %0d", err_cnt, PC ? 2 : 0); end
    checks++; if (wr_cnt !== 16'd1) begin errors++; $display("FAIL moved_wr_cnt got %0d exp 1", wr_cnt); end
    apb_read(32'h04, d);
    checks++; if (d !== 32'hA5A5A5A5) begin errors++; $display("FAIL moved_word1 got %h exp %h", d, 32'hA5A5A5A5); end
    apb_read(32'h0C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL moved_word3 got %h exp %h", d, 32'h0); end
    idle;
    checks++; if (prot_err !== PC) begin errors++; $display("FAIL proto_sticky got %b exp %b", prot_err, PC); end
  endtask

  task automatic test_async_reset;
    do_reset;
    apb_write(4'b0001, 32'h08, 32'h11111111);
    apb_read(32'h08, d);
    checks++; if (d !== 32'h11111111) begin errors++; $display("FAIL arst_pre_read got %h exp %h", d, 32'h11111111); end
    Pselx = 4'b0001; Pwrite = 1'b1; Paddr = 32'h04; Pwdata = 32'hCAFEF00D; Penable = 1'b0;
    tick;
    Penable = 1'b1;
    #2 Hrest = 1'b1;
    #1;
    checks++; if (Prdata !== 32'h0) begin errors++; $display("FAIL arst_prdata got %h exp %h", Prdata, 32'h0); end
    checks++; if (wr_cnt !== 16'd0) begin errors++; $display("FAIL arst_wr_cnt got %0d exp 0", wr_cnt); end
    checks++; if (rd_cnt !== 16'd0) begin errors++; $display("FAIL arst_rd_cnt got %0d exp 0", rd_cnt); end
    @(negedge Hclk);
    Hrest = 1'b0;
    tick;
    checks++; if (wr_cnt !== 16'd0) begin errors++; $display("FAIL arst_abandon_wr_cnt got %0d exp 0", wr_cnt); end
    checks++; if (err_cnt !== (PC ? 8'd1 : 8'd0)) begin errors++; $display("FAIL arst_abandon_err_cnt got %0d exp %0d", err_cnt, PC ? 1 : 0); end
    idle;
    apb_read(32'h04, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL arst_word1 got %h exp %h", d, 32'h0); end
    apb_read(32'h08, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL arst_word2 got %h exp %h", d, 32'h0); end
    idle;
  endtask

  initial begin
    test_reset;
    test_read_all;
    test_back_to_back;
    test_wrap_and_select;
    test_saturation;
    test_protocol;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_bank.md
Name: apb_slave_bank

Overview:
- Synthesizable APB2 (no Pready/Pslverr) completer that sits on the APB side of the AHB-to-APB bridge.
- Responds to one bit of Pselx and backs it with a reset-cleared 32-bit register bank.
- Produces Prdata so the bridge can be exercised against real RTL, not only the bench responder.
- Zero-wait-state; reports transfer counts and, optionally, protocol violations.

Parameters:
- SEL_IDX, 0: index of the Pselx bit this slave decodes (0..3).
- DEPTH, 16: number of 32-bit words; power of two, 2..256.
- CNT_W, 16: width of the wr_cnt/rd_cnt transfer counters.

Ports:
- Hclk  input  1  bridge clock; all state changes on posedge.
- Hrest  input  1  asynchronous, active-high reset.
- Pselx  input  4  peripheral selects; only Pselx[SEL_IDX] is used.
- Penable  input  1  access-phase strobe.
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  32  byte address; word index = Paddr[log2(DEPTH)+1:2]; upper bits ignored, so the index wraps.
- Pwdata  input  32  write data.
- Prdata  output  32  read data, registered.
- wr_cnt  output  CNT_W  completed writes, saturating.
- rd_cnt  output  CNT_W  completed reads, saturating.
- prot_err  output  1  sticky protocol-violation flag (optional feature).
- err_cnt  output  8  violation count, saturating at 255 (optional feature).

Behaviour:
- Reset (Hrest=1, asynchronous): every bank word = 0, Prdata = 0, wr_cnt = rd_cnt = 0, prot_err = 0, err_cnt = 0, FSM = IDLE, captured address/direction = 0. Deasserting Hrest mid-transfer abandons that transfer; the next transfer must begin with a fresh SETUP.
- sel = Pselx[SEL_IDX]. Other Pselx bits are don't-care, including when several bits are set simultaneously.
- FSM states IDLE, SETUP, ACCESS; next state from the inputs sampled at each edge:
  - sel=0 -> IDLE
  - sel=1, Penable=0 -> SETUP
  - sel=1, Penable=1 -> ACCESS
- SETUP edge (sel=1, Penable=0): capture the word index and Pwrite.
  - If read: Prdata <= bank[index] at this same edge, so Prdata is valid throughout the access cycle.
  - If write: Prdata holds its previous value.
- Access completion = edge with state==SETUP, sel=1, Penable=1.
  - Write: bank[captured index] <= Pwdata; wr_cnt += 1.
  - Read: rd_cnt += 1; Prdata unchanged.
- Prdata changes only on read SETUP edges; it holds otherwise.
- Back-to-back transfers: ACCESS -> SETUP with no IDLE is legal. A write to word N followed immediately by a read of word N returns the new data, because the write commits one edge before the read SETUP edge.
- Counters saturate at all-ones and never wrap.
- Latency: read data appears 1 edge after the setup phase is sampled; write data is visible 1 edge after the access phase is sampled.
- Only transfers completing from SETUP update the bank or counters. A transfer with sel=1, Penable=1 while the state is not SETUP changes nothing.

Optional Feature:
- Macro: APB_SLV_PROTCHK_EN
- Defined: on each edge, a violation is any one of:
  - sel=1, Penable=1 while state != SETUP (access without setup, or access held longer than one cycle);
  - sel=1, Penable=1, state==SETUP, and the word index or Pwrite differs from the captured value.
- On a violation: prot_err <= 1 (sticky until reset); err_cnt += 1, saturating at 255.
  - Access without setup: no write, no counter change.
  - Changed address or direction in the access phase: the transfer still completes using the captured index and direction.
- Not defined: no checker logic; prot_err and err_cnt are tied to 0.

Test Plan:
- Reset, then read words 0..15 (SEL_IDX=0) -> Prdata=0x00000000 for every word; rd_cnt=16, wr_cnt=0.
- Write 0xDEADBEEF to Paddr 0x08, then read Paddr 0x08 back-to-back (no IDLE) -> Prdata=0xDEADBEEF in the read access cycle; wr_cnt=1, rd_cnt=1.
- Write 0x12345678 to Paddr 0x40 (DEPTH=16, index wraps to 0), then read Paddr 0x00 -> 0x12345678. The same write with only Pselx[1] set -> no change, bank[0] reads 0.
- Preload wr_cnt near saturation (or run 65537 writes with CNT_W=16) -> wr_cnt stays 0xFFFF.
- With APB_SLV_PROTCHK_EN: Penable=1 with no preceding setup -> prot_err=1, err_cnt=1, bank unchanged. Then change Paddr 0x04 -> 0x0C between setup and access on a write of 0xA5A5A5A5 -> err_cnt=2, word 1 = 0xA5A5A5A5, word 3 untouched. Without the macro, the same stimulus leaves prot_err=0 and err_cnt=0.
- Assert Hrest during the access cycle of a write of 0xCAFEF00D to Paddr 0x04 -> all outputs 0 immediately (asynchronous); the later read of 0x04 returns 0.
